// File: rtl/layer_1_feeder.sv
// -----------------------------------------------------------------------------
// layer_1_feeder
//   Sequencer for the registered 4-input dot-product neuron (layer_1). It keeps
//   a table of NEURONS weight rows, each holding four 5-bit signed weights. Each
//   accepted activation vector is run against every row in turn on the single
//   neuron. One 12-bit signed result per row is returned on a valid/ready stream.
//
//   Handshakes: a transfer happens on a rising clk edge where valid and ready
//   are both high. The producer holds valid and data stable until that edge.
//   The feeder holds res_valid/res_data/res_idx/res_last stable until res_ready.
//
//   Build option: define LAYER_1_FEEDER_RELU_EN to clamp negative results to 0.
//   Timing and handshake behaviour are the same in both builds.
//
// Ports
//   clk, rst           clock; synchronous active-high reset
//   wt_we/addr/data    weight row write, taken only in IDLE and only when
//                      addr < NEURONS; data = {w4,w3,w2,w1}
//   act_valid/ready    activation vector handshake; act_data = {in4,in3,in2,in1}
//   res_valid/ready    result stream; res_data is the signed dot product for
//                      row res_idx; res_last marks row NEURONS-1
//   busy               high whenever the sequencer is not IDLE
//   nrn_in1..4, w1..4  registered operands to the neuron
//   nrn_out            neuron output, combinational from its input registers
// -----------------------------------------------------------------------------
module layer_1_feeder #(
   parameter int NEURONS = 4,
   parameter int AW      = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wt_we,
   input  logic [AW-1:0] wt_addr,
   input  logic [19:0]   wt_data,
   input  logic          act_valid,
   output logic          act_ready,
   input  logic [19:0]   act_data,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [11:0]   res_data,
   output logic [AW-1:0] res_idx,
   output logic          res_last,
   output logic          busy,
   output logic [4:0]    nrn_in1,
   output logic [4:0]    nrn_in2,
   output logic [4:0]    nrn_in3,
   output logic [4:0]    nrn_in4,
   output logic [4:0]    nrn_w1,
   output logic [4:0]    nrn_w2,
   output logic [4:0]    nrn_w3,
   output logic [4:0]    nrn_w4,
   input  logic [11:0]   nrn_out
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      OUT   = 2'd3
   } state_t;

   state_t        state;
   logic [AW-1:0] idx;
   logic [19:0]   act_reg;
   logic [19:0]   nrn_in_q;
   logic [19:0]   nrn_w_q;

   // Sized to the full address space so that any idx value is a legal index.
   // Rows at or above NEURONS are never written or read.
   logic [19:0]   wt_mem [2**AW];

   logic          wt_ok;
   logic [19:0]   row0_fwd;
   logic [11:0]   res_next;

   assign wt_ok = wt_we && (state == IDLE) && (32'(wt_addr) < NEURONS);

   // A row-0 write on the same edge as the vector handshake must reach the
   // neuron. The table write and the operand load happen on the same edge.
   assign row0_fwd = (wt_ok && (wt_addr == '0)) ? wt_data : wt_mem[0];

`ifdef LAYER_1_FEEDER_RELU_EN
   assign res_next = nrn_out[11] ? 12'd0 : nrn_out;
`else
   assign res_next = nrn_out;
`endif

   assign {nrn_in4, nrn_in3, nrn_in2, nrn_in1} = nrn_in_q;
   assign {nrn_w4,  nrn_w3,  nrn_w2,  nrn_w1}  = nrn_w_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         act_reg   <= '0;
         nrn_in_q  <= '0;
         nrn_w_q   <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_idx   <= '0;
         res_last  <= 1'b0;
         act_ready <= 1'b1;
         busy      <= 1'b0;
         for (int i = 0; i < 2**AW; i++) begin
            wt_mem[i] <= '0;
         end
      end else begin
         if (wt_ok) begin
            wt_mem[wt_addr] <= wt_data;
         end

         case (state)
            IDLE: begin
               if (act_valid) begin
                  // The operands are loaded here so that the neuron sees them
                  // for the whole ISSUE cycle.
                  act_reg   <= act_data;
                  idx       <= '0;
                  nrn_in_q  <= act_data;
                  nrn_w_q   <= row0_fwd;
                  act_ready <= 1'b0;
                  busy      <= 1'b1;
                  state     <= ISSUE;
               end
            end

            ISSUE: begin
               // The neuron captures its operands at the end of this cycle.
               state <= WAIT;
            end

            WAIT: begin
               res_data  <= res_next;
               res_idx   <= idx;
               res_last  <= (idx == AW'(NEURONS - 1));
               res_valid <= 1'b1;
               state     <= OUT;
            end

            OUT: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  if (res_last) begin
                     act_ready <= 1'b1;
                     busy      <= 1'b0;
                     state     <= IDLE;
                  end else begin
                     // Weights cannot change while busy, so no forwarding here.
                     idx      <= idx + AW'(1);
                     nrn_in_q <= act_reg;
                     nrn_w_q  <= wt_mem[idx + AW'(1)];
                     state    <= ISSUE;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
